// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the 32-bit bus datapath: fetch, decode of ir[31:27], Moore strobes.
// Optional macro CU_JAL_EN enables the jal instruction; otherwise opcode 10101 is undefined.
module control_sequencer #(
    parameter int IR_W     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [IR_W-1:0]     ir,
    input  logic                con_out,
    input  logic                stop,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                hi_out,
    output logic                lo_out,
    output logic                mdr_out,
    output logic                inport_out,
    output logic                c_sign_extended_out,
    output logic                ba_out,
    output logic                r_out,
    output logic                mar_enable,
    output logic                z_enable,
    output logic                lo_enable,
    output logic                hi_enable,
    output logic                pc_enable,
    output logic                mdr_enable,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                r15_enable,
    output logic                r_in,
    output logic                con_enable,
    output logic                outport_enable,
    output logic                inport_enable,
    output logic                read,
    output logic                ram_write,
    output logic                pc_increment,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                illegal_op
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'd1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'd2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'd3);

    state_t     state_r;
    state_t     next_state_s;
    state_t     boundary_s;
    logic [4:0] opcode_s;
    logic       unused_ir_s;

    assign opcode_s    = ir[IR_W-1 -: 5];
    assign unused_ir_s = ^ir[IR_W-6:0];
    assign boundary_s  = stop ? S_HALT : S_T0;

    // State register; clr aborts any instruction straight back to RST.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= S_RST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: each opcode walks the T-states it needs, then returns to T0 or HALT.
    always_comb begin
        next_state_s = S_RST;
        case (state_r)
            S_RST: next_state_s = S_T0;
            S_T0:  next_state_s = S_T1;
            S_T1:  next_state_s = S_T2;
            S_T2: begin
                if (opcode_s == OP_NOP) begin
                    next_state_s = boundary_s;
                end else if (opcode_s == OP_HALT) begin
                    next_state_s = S_HALT;
                end else begin
                    next_state_s = S_T3;
                end
            end
            S_T3: begin
                case (opcode_s)
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_BR: next_state_s = S_T4;
`ifdef CU_JAL_EN
                    OP_JAL:         next_state_s = S_T4;
`endif
                    default:        next_state_s = boundary_s;
                endcase
            end
            S_T4: begin
                case (opcode_s)
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_BR: next_state_s = S_T5;
                    default:        next_state_s = boundary_s;
                endcase
            end
            S_T5: begin
                case (opcode_s)
                    OP_LD, OP_ST, OP_BR: next_state_s = S_T6;
                    default:             next_state_s = boundary_s;
                endcase
            end
            S_T6: begin
                case (opcode_s)
                    OP_LD, OP_ST: next_state_s = S_T7;
                    default:      next_state_s = boundary_s;
                endcase
            end
            S_T7:   next_state_s = boundary_s;
            S_HALT: next_state_s = S_HALT;
            default: next_state_s = S_RST;
        endcase
    end

    // Moore strobe decode; br T6 gates pc_enable with the live CON flag.
    always_comb begin
        pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
        mdr_out = 1'b0; inport_out = 1'b0; c_sign_extended_out = 1'b0; ba_out = 1'b0; r_out = 1'b0;
        mar_enable = 1'b0; z_enable = 1'b0; lo_enable = 1'b0; hi_enable = 1'b0; pc_enable = 1'b0;
        mdr_enable = 1'b0; ir_enable = 1'b0; y_enable = 1'b0; r15_enable = 1'b0; r_in = 1'b0;
        con_enable = 1'b0; outport_enable = 1'b0; inport_enable = 1'b0;
        read = 1'b0; ram_write = 1'b0; pc_increment = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
        alu_op = ALU_ADD;
        run = 1'b1;
        illegal_op = 1'b0;
        case (state_r)
            S_T0: begin
                pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1;
            end
            S_T1: begin
                zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_enable = 1'b1;
            end
            S_T3: begin
                case (opcode_s)
                    OP_LD, OP_LDI, OP_ST: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
                    OP_ADDI, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        grb = 1'b1; r_out = 1'b1; y_enable = 1'b1;
                    end
                    OP_BR:   begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
                    OP_JR:   begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
`ifdef CU_JAL_EN
                    OP_JAL:  begin pc_out = 1'b1; r15_enable = 1'b1; end
`endif
                    OP_IN:   begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    OP_OUT:  begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
                    OP_MFHI: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    OP_MFLO: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    default: illegal_op = 1'b1;
                endcase
            end
            S_T4: begin
                case (opcode_s)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = ALU_ADD;
                    end
                    OP_ADD:  begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ALU_ADD; end
                    OP_SUB:  begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ALU_SUB; end
                    OP_AND:  begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ALU_AND; end
                    OP_OR:   begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = ALU_OR;  end
                    OP_BR:   begin pc_out = 1'b1; y_enable = 1'b1; end
`ifdef CU_JAL_EN
                    OP_JAL:  begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
`endif
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_T5: begin
                case (opcode_s)
                    OP_LDI, OP_ADDI, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end
                    OP_LD, OP_ST: begin zlo_out = 1'b1; mar_enable = 1'b1; end
                    OP_BR:   begin c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = ALU_ADD; end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_T6: begin
                case (opcode_s)
                    OP_LD:   begin read = 1'b1; mdr_enable = 1'b1; end
                    OP_ST:   begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
                    OP_BR:   begin zlo_out = 1'b1; pc_enable = con_out; end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_T7: begin
                case (opcode_s)
                    OP_LD:   begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    OP_ST:   ram_write = 1'b1;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_HALT: run = 1'b0;
            default: run = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; compares every output each T-state.
module tb_control_sequencer;

    localparam logic [28:0] PC_OUT   = 29'd1 << 28;
    localparam logic [28:0] ZLO_OUT  = 29'd1 << 27;
    localparam logic [28:0] HI_OUT   = 29'd1 << 25;
    localparam logic [28:0] LO_OUT   = 29'd1 << 24;
    localparam logic [28:0] MDR_OUT  = 29'd1 << 23;
    localparam logic [28:0] INP_OUT  = 29'd1 << 22;
    localparam logic [28:0] CSE_OUT  = 29'd1 << 21;
    localparam logic [28:0] BA_OUT   = 29'd1 << 20;
    localparam logic [28:0] R_OUT    = 29'd1 << 19;
    localparam logic [28:0] MAR_EN   = 29'd1 << 18;
    localparam logic [28:0] Z_EN     = 29'd1 << 17;
    localparam logic [28:0] PC_EN    = 29'd1 << 14;
    localparam logic [28:0] MDR_EN   = 29'd1 << 13;
    localparam logic [28:0] IR_EN    = 29'd1 << 12;
    localparam logic [28:0] Y_EN     = 29'd1 << 11;
    localparam logic [28:0] R15_EN   = 29'd1 << 10;
    localparam logic [28:0] R_IN     = 29'd1 << 9;
    localparam logic [28:0] CON_EN   = 29'd1 << 8;
    localparam logic [28:0] OUTP_EN  = 29'd1 << 7;
    localparam logic [28:0] READ     = 29'd1 << 5;
    localparam logic [28:0] RAM_WR   = 29'd1 << 4;
    localparam logic [28:0] PC_INC   = 29'd1 << 3;
    localparam logic [28:0] GRA      = 29'd1 << 2;
    localparam logic [28:0] GRB      = 29'd1 << 1;
    localparam logic [28:0] GRC      = 29'd1 << 0;
    localparam logic [34:0] ILL      = {1'b1, 1'b1, 4'd0, 29'd0};
    localparam logic [34:0] HALTED   = 35'd0;
    localparam logic [34:0] RSTW     = {1'b1, 1'b0, 4'd0, 29'd0};
    localparam logic [34:0] PAD      = 35'd0;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        con_out = 1'b0;
    logic        stop = 1'b0;
    logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out;
    logic ba_out, r_out, mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable;
    logic ir_enable, y_enable, r15_enable, r_in, con_enable, outport_enable, inport_enable;
    logic read, ram_write, pc_increment, gra, grb, grc, run, illegal_op;
    logic [3:0]  alu_op;
    logic [28:0] strobes_s;
    int          n_checks = 0;
    int          n_fail = 0;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .con_out(con_out), .stop(stop),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
        .mdr_out(mdr_out), .inport_out(inport_out), .c_sign_extended_out(c_sign_extended_out),
        .ba_out(ba_out), .r_out(r_out), .mar_enable(mar_enable), .z_enable(z_enable),
        .lo_enable(lo_enable), .hi_enable(hi_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable),
        .ir_enable(ir_enable), .y_enable(y_enable), .r15_enable(r15_enable), .r_in(r_in),
        .con_enable(con_enable), .outport_enable(outport_enable), .inport_enable(inport_enable),
        .read(read), .ram_write(ram_write), .pc_increment(pc_increment), .gra(gra), .grb(grb),
        .grc(grc), .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign strobes_s = {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out,
                        c_sign_extended_out, ba_out, r_out, mar_enable, z_enable, lo_enable,
                        hi_enable, pc_enable, mdr_enable, ir_enable, y_enable, r15_enable, r_in,
                        con_enable, outport_enable, inport_enable, read, ram_write, pc_increment,
                        gra, grb, grc};

    function automatic logic [34:0] W(input logic [28:0] s);
        return {1'b1, 1'b0, 4'd0, s};
    endfunction

    function automatic logic [34:0] WA(input logic [28:0] s, input logic [3:0] a);
        return {1'b1, 1'b0, a, s};
    endfunction

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got run/ill/alu/strobes=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [34:0] exp);
        check(tag, {run, illegal_op, alu_op, strobes_s}, exp);
        tick();
    endtask

    // Fetch plus n execute states; entered and left positioned in T0 of the instruction.
    task automatic instr(input string tag, input logic [4:0] op, input int n,
                         input logic [0:4][34:0] ex);
        ir = {op, 27'h0000095};
        cyc({tag, "/T0"}, W(PC_OUT | MAR_EN | PC_INC | Z_EN));
        cyc({tag, "/T1"}, W(ZLO_OUT | PC_EN | READ | MDR_EN));
        cyc({tag, "/T2"}, W(MDR_OUT | IR_EN));
        for (int i = 0; i < n; i++) begin
            cyc($sformatf("%s/T%0d", tag, i + 3), ex[i]);
        end
    endtask

    task automatic do_reset(input string tag);
        clr = 1'b0;
        #2;
        check(tag, {run, illegal_op, alu_op, strobes_s}, RSTW);
        clr = 1'b1;
        tick();
    endtask

    initial begin
        #12;
        check("reset", {run, illegal_op, alu_op, strobes_s}, RSTW);
        clr = 1'b1;
        tick();

        instr("ldi", 5'b00001, 3, {W(GRB | BA_OUT | Y_EN), WA(CSE_OUT | Z_EN, 4'd0),
                                   W(ZLO_OUT | GRA | R_IN), PAD, PAD});
        instr("ldi_abort", 5'b00001, 2, {W(GRB | BA_OUT | Y_EN), W(CSE_OUT | Z_EN), PAD, PAD, PAD});
        check("ldi_abort/T5", {run, illegal_op, alu_op, strobes_s}, W(ZLO_OUT | GRA | R_IN));
        #4;
        clr = 1'b0;
        #1;
        check("abort_reset", {run, illegal_op, alu_op, strobes_s}, RSTW);
        clr = 1'b1;
        tick();

        instr("st", 5'b00010, 5, {W(GRB | BA_OUT | Y_EN), W(CSE_OUT | Z_EN), W(ZLO_OUT | MAR_EN),
                                  W(GRA | R_OUT | MDR_EN), W(RAM_WR)});
        instr("ld", 5'b00000, 5, {W(GRB | BA_OUT | Y_EN), W(CSE_OUT | Z_EN), W(ZLO_OUT | MAR_EN),
                                  W(READ | MDR_EN), W(MDR_OUT | GRA | R_IN)});
        instr("add", 5'b00011, 3, {W(GRB | R_OUT | Y_EN), WA(GRC | R_OUT | Z_EN, 4'd0),
                                   W(ZLO_OUT | GRA | R_IN), PAD, PAD});
        instr("sub", 5'b00100, 3, {W(GRB | R_OUT | Y_EN), WA(GRC | R_OUT | Z_EN, 4'd1),
                                   W(ZLO_OUT | GRA | R_IN), PAD, PAD});
        instr("and", 5'b00101, 3, {W(GRB | R_OUT | Y_EN), WA(GRC | R_OUT | Z_EN, 4'd2),
                                   W(ZLO_OUT | GRA | R_IN), PAD, PAD});
        instr("or", 5'b00110, 3, {W(GRB | R_OUT | Y_EN), WA(GRC | R_OUT | Z_EN, 4'd3),
                                  W(ZLO_OUT | GRA | R_IN), PAD, PAD});
        instr("addi", 5'b01100, 3, {W(GRB | R_OUT | Y_EN), W(CSE_OUT | Z_EN),
                                    W(ZLO_OUT | GRA | R_IN), PAD, PAD});
        con_out = 1'b0;
        instr("br_nt", 5'b10010, 4, {W(GRA | R_OUT | CON_EN), W(PC_OUT | Y_EN), W(CSE_OUT | Z_EN),
                                     W(ZLO_OUT), PAD});
        con_out = 1'b1;
        instr("br_t", 5'b10010, 4, {W(GRA | R_OUT | CON_EN), W(PC_OUT | Y_EN), W(CSE_OUT | Z_EN),
                                    W(ZLO_OUT | PC_EN), PAD});
        con_out = 1'b0;
        instr("jr", 5'b10100, 1, {W(GRA | R_OUT | PC_EN), PAD, PAD, PAD, PAD});
`ifdef CU_JAL_EN
        instr("jal", 5'b10101, 2, {W(PC_OUT | R15_EN), W(GRA | R_OUT | PC_EN), PAD, PAD, PAD});
`else
        instr("jal_undef", 5'b10101, 1, {ILL, PAD, PAD, PAD, PAD});
`endif
        instr("in", 5'b10110, 1, {W(INP_OUT | GRA | R_IN), PAD, PAD, PAD, PAD});
        instr("out", 5'b10111, 1, {W(GRA | R_OUT | OUTP_EN), PAD, PAD, PAD, PAD});
        instr("mfhi", 5'b11000, 1, {W(HI_OUT | GRA | R_IN), PAD, PAD, PAD, PAD});
        instr("mflo", 5'b11001, 1, {W(LO_OUT | GRA | R_IN), PAD, PAD, PAD, PAD});
        instr("nop", 5'b11010, 0, {PAD, PAD, PAD, PAD, PAD});
        instr("illegal", 5'b11111, 1, {ILL, PAD, PAD, PAD, PAD});
        instr("halt", 5'b11011, 0, {PAD, PAD, PAD, PAD, PAD});
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("halted%0d", i), HALTED);
        end
        do_reset("halt_clr");

        stop = 1'b1;
        instr("out_stop", 5'b10111, 1, {W(GRA | R_OUT | OUTP_EN), PAD, PAD, PAD, PAD});
        stop = 1'b0;
        cyc("stop_halt0", HALTED);
        cyc("stop_halt1", HALTED);
        do_reset("stop_clr");

        instr("final_jr", 5'b10100, 1, {W(GRA | R_OUT | PC_EN), PAD, PAD, PAD, PAD});
        cyc("final_T0", W(PC_OUT | MAR_EN | PC_INC | Z_EN));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
